uart_tx_buffered: RTL and testbench

Parametrised UART transmitter with an internal transmit FIFO. It is the successor to the single-byte transmitter. Data width, stop bits, parity and FIFO depth are configurable, and upstream uses a valid/ready handshake. Queued frames go out back-to-back with no idle gap. It sits between the system-bus write path and the uart_tx pad.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_buffered.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared FSM encoding, parity constants and helper functions for the UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PARITY_EVEN    = 0;
    localparam int unsigned PARITY_ODD     = 1;
    localparam int unsigned MAX_DATA_WIDTH = 9;

    // Clock cycles per bit, truncated.
    function automatic int unsigned baud_div(input int unsigned clk_mhz, input int unsigned bps);
        return (clk_mhz * 32'd1000000) / bps;
    endfunction

    // Zero-extended words give the same XOR, so one width serves every DATA_WIDTH.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level and show-ahead read data.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign pop_data_c = mem[rd_ptr[AW-1:0]];

    always_comb begin
        wr_ptr_nxt = wr_ptr + (AW+1)'(do_push);
        rd_ptr_nxt = rd_ptr + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            level  <= wr_ptr_nxt - rd_ptr_nxt;
        end
    end

    // Storage is not reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed from an internal FIFO; queued frames are sent back-to-back.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CLK_FREQ    = 50,
    parameter int unsigned BPS         = 115200,
    parameter int unsigned PARITY_ON   = 1,
    parameter int unsigned PARITY_TYPE = 1,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk_sys,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BPS);
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W    = 4;

    uart_state_e           state;
    uart_state_e           state_nxt;
    logic [CNT_W-1:0]      baud_cnt;
    logic [CNT_W-1:0]      baud_cnt_nxt;
    logic [BIT_W-1:0]      bit_idx;
    logic [BIT_W-1:0]      bit_idx_nxt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  parity_reg;
    logic                  parity_nxt;
    logic                  tx_nxt;
    logic                  done_nxt;
    logic                  bit_end;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_sys),
        .rst_n      (rst_n),
        .push       (tx_valid),
        .push_data  (tx_data),
        .pop        (fifo_pop),
        .pop_data_c (fifo_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    assign tx_ready = ~fifo_full;
    assign bit_end  = (baud_cnt == CNT_W'(BAUD_DIV - 1));

    // Next-state, next line value and FIFO pop.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_reg;
        parity_nxt   = parity_reg;
        tx_nxt       = uart_tx;
        done_nxt     = 1'b0;
        fifo_pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_cnt_nxt = '0;
                tx_nxt       = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_START;
                    tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = '0;
                    tx_nxt      = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_idx_nxt = '0;
                        if (PARITY_ON != 0) begin
                            state_nxt = ST_PARITY;
                            tx_nxt    = parity_reg;
                        end else begin
                            state_nxt = ST_STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                        shift_nxt   = shift_reg >> 1;
                        tx_nxt      = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_nxt = ST_STOP;
                    tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
                        done_nxt    = 1'b1;
                        bit_idx_nxt = '0;
                        if (!fifo_empty) begin
                            fifo_pop  = 1'b1;
                            state_nxt = ST_START;
                            tx_nxt    = 1'b0;
                        end else begin
                            state_nxt = ST_IDLE;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
        if (fifo_pop) begin
            shift_nxt  = fifo_data;
            parity_nxt = parity_bit(MAX_DATA_WIDTH'(fifo_data), (PARITY_TYPE == PARITY_ODD));
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            uart_tx    <= 1'b1;
            tx_done    <= 1'b0;
            tx_busy    <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_reg  <= shift_nxt;
            parity_reg <= parity_nxt;
            uart_tx    <= tx_nxt;
            tx_done    <= done_nxt;
            tx_busy    <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: five instances cover the default, deep-queue, and mode variants.
module tb_uart_tx_buffered;

    localparam int NDUT     = 5;
    localparam int DIV0     = 434;
    localparam int DIV_FAST = 43;
    localparam int DIV4     = 5208;

    typedef struct {
        int         id;
        int         dut;
        logic [8:0] data;
        int         nbits;
        int         div;
        logic [11:0] bits;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_v [NDUT];
    logic [8:0] data_v  [NDUT];
    logic       ready_w [NDUT];
    logic       line_w  [NDUT];
    logic       busy_w  [NDUT];
    logic       done_w  [NDUT];
    logic [4:0] lvl0, lvl2, lvl3, lvl4;
    logic [2:0] lvl1;

    int cyc = 0;
    int done_cnt [NDUT] = '{default: 0};
    int last_done [NDUT] = '{default: 0};
    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    uart_tx_buffered #(.DATA_WIDTH(8), .CLK_FREQ(50), .BPS(115200), .PARITY_ON(1),
                       .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
        .clk_sys(clk), .rst_n(rst_n), .tx_valid(valid_v[0]), .tx_ready(ready_w[0]),
        .tx_data(data_v[0][7:0]), .uart_tx(line_w[0]), .tx_busy(busy_w[0]),
        .tx_done(done_w[0]), .fifo_level(lvl0));

    uart_tx_buffered #(.DATA_WIDTH(8), .CLK_FREQ(5), .BPS(115200), .PARITY_ON(1),
                       .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clk_sys(clk), .rst_n(rst_n), .tx_valid(valid_v[1]), .tx_ready(ready_w[1]),
        .tx_data(data_v[1][7:0]), .uart_tx(line_w[1]), .tx_busy(busy_w[1]),
        .tx_done(done_w[1]), .fifo_level(lvl1));

    uart_tx_buffered #(.DATA_WIDTH(7), .CLK_FREQ(5), .BPS(115200), .PARITY_ON(0),
                       .PARITY_TYPE(1), .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
        .clk_sys(clk), .rst_n(rst_n), .tx_valid(valid_v[2]), .tx_ready(ready_w[2]),
        .tx_data(data_v[2][6:0]), .uart_tx(line_w[2]), .tx_busy(busy_w[2]),
        .tx_done(done_w[2]), .fifo_level(lvl2));

    uart_tx_buffered #(.DATA_WIDTH(8), .CLK_FREQ(5), .BPS(115200), .PARITY_ON(1),
                       .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut3 (
        .clk_sys(clk), .rst_n(rst_n), .tx_valid(valid_v[3]), .tx_ready(ready_w[3]),
        .tx_data(data_v[3][7:0]), .uart_tx(line_w[3]), .tx_busy(busy_w[3]),
        .tx_done(done_w[3]), .fifo_level(lvl3));

    uart_tx_buffered #(.DATA_WIDTH(8), .CLK_FREQ(50), .BPS(9600), .PARITY_ON(1),
                       .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut4 (
        .clk_sys(clk), .rst_n(rst_n), .tx_valid(valid_v[4]), .tx_ready(ready_w[4]),
        .tx_data(data_v[4][7:0]), .uart_tx(line_w[4]), .tx_busy(busy_w[4]),
        .tx_done(done_w[4]), .fifo_level(lvl4));

    function automatic int level_of(input int d);
        case (d)
            0:       return int'(lvl0);
            1:       return int'(lvl1);
            2:       return int'(lvl2);
            3:       return int'(lvl3);
            default: return int'(lvl4);
        endcase
    endfunction

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Queue one word; p is the cycle count of the accepting edge.
    task automatic push_word(input int d, input logic [8:0] w, output int p);
        int guard = 0;
        @(negedge clk);
        valid_v[d] = 1'b1;
        data_v[d]  = w;
        while (!ready_w[d] && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_w[d]) timed_out($sformatf("push_dut%0d", d));
        @(negedge clk);
        p          = cyc;
        valid_v[d] = 1'b0;
    endtask

    // Sample every bit mid-period and check the frame length via tx_done.
    task automatic check_frame(input frame_t f, input bit b2b, output int c0);
        int guard = 0;
        int d;
        d = f.dut;
        while (line_w[d] !== 1'b0 && guard < 16 * f.div) begin
            @(negedge clk);
            guard++;
        end
        c0 = cyc;
        if (line_w[d] !== 1'b0) begin
            timed_out($sformatf("f%0d_start", f.id));
            return;
        end
        if (b2b) check_eq($sformatf("f%0d_gap", f.id), c0 - last_done[d], 0);
        repeat (f.div / 2) @(negedge clk);
        check_eq($sformatf("f%0d_busy", f.id), busy_w[d], 1);
        for (int i = 0; i < f.nbits; i++) begin
            check_eq($sformatf("f%0d_bit%0d", f.id, i), line_w[d], f.bits[i]);
            if (i < f.nbits - 1) repeat (f.div) @(negedge clk);
        end
        guard = 0;
        while (!done_w[d] && guard < f.div) begin
            @(negedge clk);
            guard++;
        end
        check_eq($sformatf("f%0d_len", f.id), cyc - c0, f.nbits * f.div);
        last_done[d] = cyc;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    frame_t singles [4];
    frame_t b2b_v   [3];
    frame_t full_v  [6];
    frame_t f_after;

    initial begin
        int p, c0, dc, guard, peak, max_lvl, ready_bad, saw_full;

        // Bits listed as {stop(s), parity, data, start}; bit 0 goes out first.
        singles[0] = '{id: 0, dut: 0, data: 9'h0C9, nbits: 11, div: DIV0,     bits: 12'b0_1_1_11001001_0};
        singles[1] = '{id: 1, dut: 2, data: 9'h041, nbits: 10, div: DIV_FAST, bits: 12'b00_1_1_1000001_0};
        singles[2] = '{id: 2, dut: 3, data: 9'h0FF, nbits: 11, div: DIV_FAST, bits: 12'b0_1_0_11111111_0};
        singles[3] = '{id: 3, dut: 3, data: 9'h001, nbits: 11, div: DIV_FAST, bits: 12'b0_1_1_00000001_0};
        b2b_v[0]   = '{id: 10, dut: 0, data: 9'h055, nbits: 11, div: DIV0, bits: 12'b0_1_1_01010101_0};
        b2b_v[1]   = '{id: 11, dut: 0, data: 9'h0A3, nbits: 11, div: DIV0, bits: 12'b0_1_1_10100011_0};
        b2b_v[2]   = '{id: 12, dut: 0, data: 9'h00F, nbits: 11, div: DIV0, bits: 12'b0_1_1_00001111_0};
        full_v[0]  = '{id: 20, dut: 1, data: 9'h001, nbits: 11, div: DIV_FAST, bits: 12'b0_1_0_00000001_0};
        full_v[1]  = '{id: 21, dut: 1, data: 9'h080, nbits: 11, div: DIV_FAST, bits: 12'b0_1_0_10000000_0};
        full_v[2]  = '{id: 22, dut: 1, data: 9'h007, nbits: 11, div: DIV_FAST, bits: 12'b0_1_0_00000111_0};
        full_v[3]  = '{id: 23, dut: 1, data: 9'h0FE, nbits: 11, div: DIV_FAST, bits: 12'b0_1_0_11111110_0};
        full_v[4]  = '{id: 24, dut: 1, data: 9'h03C, nbits: 11, div: DIV_FAST, bits: 12'b0_1_1_00111100_0};
        full_v[5]  = '{id: 25, dut: 1, data: 9'h0A5, nbits: 11, div: DIV_FAST, bits: 12'b0_1_1_10100101_0};
        f_after    = '{id: 30, dut: 0, data: 9'h03C, nbits: 11, div: DIV0, bits: 12'b0_1_1_00111100_0};

        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            valid_v[i] = 1'b0;
            data_v[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_line",  line_w[0], 1);
        check_eq("rst_busy",  busy_w[0], 0);
        check_eq("rst_done",  done_w[0], 0);
        check_eq("rst_level", lvl0, 0);
        check_eq("rst_ready", ready_w[0], 1);
        check_eq("rst_ready1", ready_w[1], 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_line", line_w[0], 1);

        // Single frames across the parameter variants.
        for (int k = 0; k < 4; k++) begin
            dc = done_cnt[singles[k].dut];
            push_word(singles[k].dut, singles[k].data, p);
            check_eq($sformatf("f%0d_level_after_push", singles[k].id), level_of(singles[k].dut), 1);
            check_frame(singles[k], 1'b0, c0);
            check_eq($sformatf("f%0d_start_latency", singles[k].id), c0 - p, 1);
            repeat (2) @(negedge clk);
            check_eq($sformatf("f%0d_done_pulses", singles[k].id), done_cnt[singles[k].dut] - dc, 1);
            check_eq($sformatf("f%0d_idle_after", singles[k].id), line_w[singles[k].dut], 1);
        end

        // Three words pushed in consecutive cycles.
        dc   = done_cnt[0];
        peak = 0;
        fork
            begin
                @(negedge clk);
                valid_v[0] = 1'b1;
                data_v[0]  = 9'h055;
                @(negedge clk);
                data_v[0]  = 9'h0A3;
                @(negedge clk);
                data_v[0]  = 9'h00F;
                @(negedge clk);
                valid_v[0] = 1'b0;
                repeat (20) begin
                    if (int'(lvl0) > peak) peak = int'(lvl0);
                    @(negedge clk);
                end
            end
            begin
                for (int k = 0; k < 3; k++) check_frame(b2b_v[k], (k > 0), c0);
            end
        join
        check_eq("b2b_level_peak", peak, 2);
        check_eq("b2b_busy_after", busy_w[0], 0);
        repeat (2) @(negedge clk);
        check_eq("b2b_done_pulses", done_cnt[0] - dc, 3);

        // Depth-4 FIFO with tx_valid held high through the full condition.
        max_lvl   = 0;
        ready_bad = 0;
        saw_full  = 0;
        fork
            begin
                @(negedge clk);
                valid_v[1] = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    data_v[1] = full_v[k].data;
                    guard = 0;
                    while (!ready_w[1] && guard < 2000) begin
                        saw_full = 1;
                        if (ready_w[1] != (lvl1 != 3'd4)) ready_bad++;
                        if (int'(lvl1) > max_lvl) max_lvl = int'(lvl1);
                        @(negedge clk);
                        guard++;
                    end
                    if (ready_w[1] != (lvl1 != 3'd4)) ready_bad++;
                    if (int'(lvl1) > max_lvl) max_lvl = int'(lvl1);
                    @(negedge clk);
                end
                valid_v[1] = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) check_frame(full_v[k], (k > 0), c0);
            end
        join
        check_eq("full_max_level", max_lvl, 4);
        check_eq("full_saw_not_ready", saw_full, 1);
        check_eq("full_ready_vs_level", ready_bad, 0);
        check_eq("full_level_drained", lvl1, 0);

        // Reset during data bit 3 with a second word still queued.
        dc = done_cnt[0];
        push_word(0, 9'h000, p);
        c0 = p + 1;
        push_word(0, 9'h000, guard);
        while (cyc < c0 + 4 * DIV0 + DIV0 / 2) @(negedge clk);
        check_eq("mid_line_low", line_w[0], 0);
        check_eq("mid_level", lvl0, 1);
        check_eq("mid_busy", busy_w[0], 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_line", line_w[0], 1);
        check_eq("abort_busy", busy_w[0], 0);
        check_eq("abort_level", lvl0, 0);
        check_eq("abort_ready", ready_w[0], 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("post_rst_line", line_w[0], 1);
        check_eq("post_rst_busy", busy_w[0], 0);
        push_word(0, f_after.data, p);
        check_frame(f_after, 1'b0, c0);
        check_eq("post_rst_latency", c0 - p, 1);
        repeat (2) @(negedge clk);
        check_eq("post_rst_done_pulses", done_cnt[0] - dc, 1);

        // 9600 baud start-bit width.
        push_word(4, 9'h001, p);
        guard = 0;
        while (line_w[4] !== 1'b0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        c0 = cyc;
        if (line_w[4] !== 1'b0) begin
            timed_out("div9600_start");
        end else begin
            check_eq("div9600_latency", c0 - p, 1);
            guard = 0;
            while (line_w[4] === 1'b0 && guard < 6000) begin
                @(negedge clk);
                guard++;
            end
            check_eq("div9600_start_width", cyc - c0, DIV4);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
